// File: rtl/dnn_accuracy_monitor.sv
// Accuracy monitor for the DNN training output stream: captures the serialized
// ideal outputs each block cycle and scores them against the thresholded outputs.
module dnn_accuracy_monitor #(
   parameter int n_out          = 16,
   parameter int yw             = 1,
   parameter int cpc            = 18,
   parameter int checklast      = 1000,
   parameter int training_cases = 10000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [$clog2(cpc)-1:0]         cycle_index,
   input  logic [yw-1:0]                  y_out,
   input  logic [n_out-1:0]               a_out_alln,
   output logic                           correct,
   output logic                           result_valid,
   output logic [$clog2(checklast+1)-1:0] recent,
   output logic [31:0]                    total_correct,
   output logic [31:0]                    num_train,
   output logic [15:0]                    epoch,
   output logic                           epoch_done,
   output logic [1:0]                     state_dbg
);

   localparam int CIW = $clog2(cpc);
   localparam int RW  = $clog2(checklast + 1);
   localparam int PW  = (checklast > 1) ? $clog2(checklast) : 1;
   localparam int TW  = (training_cases > 1) ? $clog2(training_cases) : 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] EVAL    = 2'd2;

   localparam logic [CIW-1:0] FIRST_IDX = CIW'(2);
   localparam logic [CIW-1:0] LAST_IDX  = CIW'(cpc - 1);
   localparam logic [RW-1:0]  FILL_MAX  = RW'(checklast);
   localparam logic [PW-1:0]  PTR_LAST  = PW'(checklast - 1);
   localparam logic [TW-1:0]  TC_LAST   = TW'(training_cases - 1);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CIW-1:0]   last_idx;
   logic [CIW-1:0]   next_idx;
   logic [CIW-1:0]   slot;
   logic [n_out-1:0] ideal;
   logic             cap_en;
   logic             eval_en;
   logic             match;
   logic             old_bit;
   logic [RW-1:0]    recent_nxt;
   logic [RW-1:0]    fill;
   logic [PW-1:0]    ptr;
   logic [TW-1:0]    tc;
   logic             hist [checklast];

   assign state_dbg = state;
   assign next_idx  = last_idx + CIW'(1);
   assign slot      = cycle_index - FIRST_IDX;

   always_comb begin
      state_nxt = state;
      cap_en    = 1'b0;
      eval_en   = 1'b0;
      case (state)
         IDLE: begin
            if (cycle_index == FIRST_IDX) begin
               state_nxt = CAPTURE;
               cap_en    = 1'b1;
            end
         end
         CAPTURE: begin
            // A skipped or repeated index means the block is corrupt; drop it.
            if (cycle_index != next_idx) begin
               state_nxt = IDLE;
            end else begin
               cap_en = (cycle_index >= FIRST_IDX);
               if (cycle_index == LAST_IDX) state_nxt = EVAL;
            end
         end
         EVAL: begin
            eval_en   = 1'b1;
            state_nxt = CAPTURE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The evicted history bit is read before this edge's write lands.
   assign match      = (a_out_alln == ideal);
   assign old_bit    = (fill == FILL_MAX) ? hist[ptr] : 1'b0;
   assign recent_nxt = recent + RW'(match) - RW'(old_bit);

   // result_valid: single-cycle strobe, no back-pressure; every counter output
   // holds its new value for the cycle in which it is high and afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         last_idx      <= '0;
         ideal         <= '0;
         correct       <= 1'b0;
         result_valid  <= 1'b0;
         recent        <= '0;
         total_correct <= '0;
         num_train     <= '0;
         epoch         <= '0;
         epoch_done    <= 1'b0;
         fill          <= '0;
         ptr           <= '0;
         tc            <= '0;
      end else begin
         state        <= state_nxt;
         last_idx     <= cycle_index;
         result_valid <= eval_en;
         epoch_done   <= 1'b0;
         if (cap_en) ideal[slot*yw +: yw] <= y_out;
         if (eval_en) begin
            correct       <= match;
            recent        <= recent_nxt;
            total_correct <= total_correct + 32'(match);
            num_train     <= num_train + 32'd1;
            if (fill != FILL_MAX) fill <= fill + RW'(1);
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
            if (tc == TC_LAST) begin
               tc         <= '0;
               epoch      <= epoch + 16'd1;
               epoch_done <= 1'b1;
            end else begin
               tc <= tc + TW'(1);
            end
         end
      end
   end

   // History has no reset so it can map to RAM; fill says which entries are live.
   always_ff @(posedge clk) begin
      if (eval_en) hist[ptr] <= match;
   end

endmodule

// File: tb/tb_dnn_accuracy_monitor.sv
// Scoreboard bench for dnn_accuracy_monitor with a small window/epoch model.
module tb_dnn_accuracy_monitor;

   localparam int N_OUT          = 16;
   localparam int YW             = 1;
   localparam int CPC            = 18;
   localparam int CHECKLAST      = 4;
   localparam int TRAINING_CASES = 6;
   localparam int EW             = 85;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  cycle_index = '0;
   logic [0:0]  y_out = '0;
   logic [15:0] a_out_alln = '0;
   logic        correct;
   logic        result_valid;
   logic [2:0]  recent;
   logic [31:0] total_correct;
   logic [31:0] num_train;
   logic [15:0] epoch;
   logic        epoch_done;
   logic [1:0]  state_dbg;

   dnn_accuracy_monitor #(
      .n_out(N_OUT), .yw(YW), .cpc(CPC),
      .checklast(CHECKLAST), .training_cases(TRAINING_CASES)
   ) dut (
      .clk(clk), .reset(reset), .cycle_index(cycle_index), .y_out(y_out),
      .a_out_alln(a_out_alln), .correct(correct), .result_valid(result_valid),
      .recent(recent), .total_correct(total_correct), .num_train(num_train),
      .epoch(epoch), .epoch_done(epoch_done), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int fails = 0;
   logic [EW-1:0] exp_q[$];

   bit          m_win[$];
   int unsigned m_total;
   int unsigned m_num;
   int          m_tc;
   logic [15:0] m_epoch;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_win.delete();
      m_total = 0;
      m_num   = 0;
      m_tc    = 0;
      m_epoch = '0;
      exp_q.delete();
   endtask

   task automatic model_push(input logic [15:0] a, input logic [15:0] ideal);
      logic       m;
      logic [2:0] r;
      logic       d;
      bit         dropped;
      m = (a == ideal);
      m_num++;
      m_total += 32'(m);
      m_win.push_back(m);
      if (m_win.size() > CHECKLAST) dropped = m_win.pop_front();
      r = '0;
      foreach (m_win[i]) r += 3'(m_win[i]);
      d = 1'b0;
      m_tc++;
      if (m_tc == TRAINING_CASES) begin
         m_tc = 0;
         m_epoch++;
         d = 1'b1;
      end
      exp_q.push_back({m, r, m_total, m_num, m_epoch, d});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   // One block: indices first..CPC-1; a_out_alln for this case is held from
   // index 1 through index 0 of the following block.
   task automatic drive_block(input logic [15:0] a, input logic [15:0] ideal,
                              input int first, input int skip_at, input bit push);
      for (int k = first; k < CPC; k++) begin
         if (k == skip_at) continue;
         cycle_index = 5'(k);
         if (k >= 2) y_out = ideal[k-2];
         else        y_out = 1'b0;
         if (k == 1) a_out_alln = a;
         tick();
      end
      if (push) model_push(a, ideal);
   endtask

   task automatic flush();
      cycle_index = 5'd0;
      tick();
      cycle_index = 5'd1;
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
      tick();
      tick();
      tests_run++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL flush_timeout pending=%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (epoch_done && !result_valid) begin
         tests_run++;
         fails++;
         $display("FAIL epoch_done_alone epoch_done=1 result_valid=0");
      end
      if (result_valid) begin
         if (exp_q.size() == 0) begin
            tests_run++;
            fails++;
            $display("FAIL unexpected_result num_train=%0d", num_train);
         end else begin
            e = exp_q.pop_front();
            tests_run += 6;
            if (correct !== e[84]) begin
               fails++; $display("FAIL sb_correct got=%0d exp=%0d", correct, e[84]);
            end
            if (recent !== e[83:81]) begin
               fails++; $display("FAIL sb_recent got=%0d exp=%0d", recent, e[83:81]);
            end
            if (total_correct !== e[80:49]) begin
               fails++; $display("FAIL sb_total_correct got=%0d exp=%0d", total_correct, e[80:49]);
            end
            if (num_train !== e[48:17]) begin
               fails++; $display("FAIL sb_num_train got=%0d exp=%0d", num_train, e[48:17]);
            end
            if (epoch !== e[16:1]) begin
               fails++; $display("FAIL sb_epoch got=%0d exp=%0d", epoch, e[16:1]);
            end
            if (epoch_done !== e[0]) begin
               fails++; $display("FAIL sb_epoch_done got=%0d exp=%0d", epoch_done, e[0]);
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      tests_run += 4;
      if ({correct, result_valid, epoch_done} !== 3'b000) begin
         fails++; $display("FAIL reset_flags got=%b exp=000", {correct, result_valid, epoch_done});
      end
      if (recent !== 3'd0 || epoch !== 16'd0) begin
         fails++; $display("FAIL reset_recent_epoch got=%0d/%0d exp=0/0", recent, epoch);
      end
      if (total_correct !== 32'd0 || num_train !== 32'd0) begin
         fails++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", total_correct, num_train);
      end
      if (state_dbg !== 2'd0) begin
         fails++; $display("FAIL reset_state got=%0d exp=0", state_dbg);
      end
   endtask

   task automatic test_midblock_reset();
      model_reset();
      reset = 1'b0;
      drive_block(16'h0204, 16'h0204, 7, -1, 1'b0);
      drive_block(16'h1111, 16'h1111, 0, -1, 1'b1);
      flush();
      tests_run++;
      if (num_train !== 32'd1) begin
         fails++; $display("FAIL midblock_num_train got=%0d exp=1", num_train);
      end
   endtask

   task automatic test_correct_case();
      do_reset();
      drive_block(16'h0204, 16'h0204, 0, -1, 1'b1);
      flush();
      tests_run += 3;
      if (correct !== 1'b1) begin
         fails++; $display("FAIL correct_case got=%0d exp=1", correct);
      end
      if (recent !== 3'd1) begin
         fails++; $display("FAIL correct_recent got=%0d exp=1", recent);
      end
      if (total_correct !== 32'd1) begin
         fails++; $display("FAIL correct_total got=%0d exp=1", total_correct);
      end
   endtask

   task automatic test_mismatch();
      drive_block(16'h8204, 16'h0204, 0, -1, 1'b1);
      flush();
      tests_run += 3;
      if (correct !== 1'b0) begin
         fails++; $display("FAIL mismatch_correct got=%0d exp=0", correct);
      end
      if (total_correct !== 32'd1) begin
         fails++; $display("FAIL mismatch_total got=%0d exp=1", total_correct);
      end
      if (num_train !== 32'd2) begin
         fails++; $display("FAIL mismatch_num_train got=%0d exp=2", num_train);
      end
   endtask

   task automatic test_window();
      bit          pat [6] = '{1, 1, 0, 1, 0, 0};
      logic [15:0] ideal;
      logic [15:0] a;
      do_reset();
      foreach (pat[i]) begin
         ideal = 16'($urandom_range(0, 65535));
         a = pat[i] ? ideal : ideal ^ (16'h0001 << $urandom_range(0, 15));
         drive_block(a, ideal, 0, -1, 1'b1);
      end
      flush();
      tests_run += 3;
      if (recent !== 3'd1) begin
         fails++; $display("FAIL window_recent got=%0d exp=1", recent);
      end
      if (epoch !== 16'd1) begin
         fails++; $display("FAIL window_epoch got=%0d exp=1", epoch);
      end
      if (total_correct !== 32'd3) begin
         fails++; $display("FAIL window_total got=%0d exp=3", total_correct);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ideal;
      logic [15:0] a;
      for (int i = 0; i < TRAINING_CASES; i++) begin
         ideal = 16'($urandom_range(0, 65535));
         a = ($urandom_range(0, 1) == 1) ? ideal : ~ideal;
         drive_block(a, ideal, 0, -1, 1'b1);
      end
      flush();
      tests_run += 2;
      if (epoch !== 16'd2) begin
         fails++; $display("FAIL b2b_epoch got=%0d exp=2", epoch);
      end
      if (num_train !== 32'd12) begin
         fails++; $display("FAIL b2b_num_train got=%0d exp=12", num_train);
      end
   endtask

   task automatic test_out_of_sequence();
      drive_block(16'h00f0, 16'h00f0, 0, 10, 1'b0);
      drive_block(16'h3c3c, 16'h3c3c, 0, -1, 1'b1);
      flush();
      tests_run++;
      if (num_train !== 32'd13) begin
         fails++; $display("FAIL oos_num_train got=%0d exp=13", num_train);
      end
   endtask

   task automatic test_eval_reset();
      do_reset();
      drive_block(16'h0aa0, 16'h0aa0, 0, -1, 1'b0);
      cycle_index = 5'd0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests_run += 2;
      if ({result_valid, correct, recent} !== 5'd0) begin
         fails++; $display("FAIL eval_reset_flags got=%b exp=00000", {result_valid, correct, recent});
      end
      if (num_train !== 32'd0 || total_correct !== 32'd0) begin
         fails++; $display("FAIL eval_reset_counts got=%0d/%0d exp=0/0", num_train, total_correct);
      end
      cycle_index = 5'd1;
      tick();
      model_reset();
      drive_block(16'h5555, 16'h5555, 0, -1, 1'b1);
      flush();
      tests_run++;
      if (num_train !== 32'd1) begin
         fails++; $display("FAIL eval_reset_next got=%0d exp=1", num_train);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_midblock_reset();
      test_correct_case();
      test_mismatch();
      test_window();
      test_back_to_back();
      test_out_of_sequence();
      test_eval_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/dnn_accuracy_monitor.md
# dnn_accuracy_monitor

On-chip receiver for the DNN output stream during training. Each block cycle it collects the serialized ideal outputs `y_out`, then compares them against the thresholded network output `a_out_alln`. It keeps per-case correctness, a sliding-window correct count, a running total and epoch counters. These are the same statistics the MNIST training bench computes, but synthesizable, so they can be read from hardware.

## Interface
- `n_out`, 16: output neurons, n[L-1].
- `yw`, 1: ideal-output bits per clock, z[L-2]/fi[L-2]. Must satisfy n_out/yw == cpc-2.
- `cpc`, 18: clocks per block cycle, n[0]*fo[0]/z[0]+2.
- `checklast`, 1000: sliding-window depth in training cases.
- `training_cases`, 10000: cases per epoch.

Ports:
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-high.
- `cycle_index` input $clog2(cpc): block-cycle position from `cycle_block_counter`.
- `y_out` input yw: ideal-output slice from the DNN, valid for cycle_index 2..cpc-1.
- `a_out_alln` input n_out: thresholded network outputs, stable at cycle_index==0.
- `correct` output 1: result of the last evaluated case.
- `result_valid` output 1: one-clock pulse when the counters update.
- `recent` output $clog2(checklast+1): number correct among the last min(num_train, checklast) cases.
- `total_correct` output 32: correct cases since reset.
- `num_train` output 32: cases evaluated since reset.
- `epoch` output 16: completed epochs.
- `epoch_done` output 1: one-clock pulse coincident with result_valid on the last case of an epoch.

## Operation
- FSM states and transitions:
  - IDLE → CAPTURE when cycle_index==2.
  - CAPTURE → EVAL on the edge where cycle_index==cpc-1.
  - EVAL → CAPTURE on the next edge. That edge is cycle_index==0.
- A block already in progress at reset release is discarded, because IDLE waits for cycle_index==2.
- Capture rule: on each edge in CAPTURE or IDLE→CAPTURE with cycle_index=k in [2, cpc-1], `ideal[(k-2)*yw +: yw] <= y_out`.
- EVAL edge:
  - `match = (a_out_alln == ideal)`, all n_out bits compared.
  - `correct <= match`.
  - `hist[ptr] <= match`.
  - `recent <= recent + match - old`. `old` is `hist[ptr]` if `fill == checklast`, else 0.
  - `fill` saturates at checklast.
  - `ptr` wraps from checklast-1 to 0.
  - `total_correct` and `num_train` increment; `total_correct` adds `match`.
  - `tc` (case in epoch) wraps from training_cases-1 to 0. On wrap, `epoch` increments and `epoch_done` pulses.
- `hist` is a 1-bit × checklast array without reset, so it is RAM-inferrable. Validity is tracked by `fill` alone.
- Counters wrap silently: 32-bit wrap for total_correct and num_train, 16-bit wrap for epoch.
- If cycle_index is out of sequence in CAPTURE (value not equal to previous+1), the FSM returns to IDLE and the block is dropped. No counter changes.

## Timing
- Reset values:
  - All outputs 0.
  - state=IDLE; fill=0, ptr=0, tc=0, ideal=0.
- Reset is asynchronous at any point. Mid-EVAL it suppresses that update entirely.
- Latency: correct, recent and the counters are valid on the clock after the edge where cycle_index==0. result_valid is high during exactly that clock.
- recent never exceeds fill.
- The same-edge read of old `hist[ptr]` and write of the new value must use the old value (read-before-write).
- epoch_done is high only when result_valid is high.

## Test plan
All scenarios use n_out=16, yw=1, cpc=18, checklast=4, training_cases=6.
- Reset release mid-block (first cycle_index=7) → that block is ignored. The first result_valid appears one block later; num_train=1.
- y_out serialized equal to a_out_alln=16'h0204 → correct=1, recent=1, total_correct=1.
- Case with one bit mismatched (bit 15) → correct=0, total_correct unchanged, num_train incremented.
- Pattern C,C,W,C,W,W (C=correct, W=wrong) → recent sequence 1,2,2,3,2,1. The 5th and 6th cases evict the 1st and 2nd cases.
- 6 cases → epoch_done pulses with the 6th result_valid, epoch=1, tc back to 0. After 12 cases, epoch=2.
- Reset asserted on the EVAL edge → all outputs 0 and no result_valid. The next full block yields num_train=1.
